// File: rtl/foc_pkg.sv
// rtl/foc_pkg.sv - shared types, widths and saturating helpers for the FOC PI scheduler
package foc_pkg;

    localparam int N_DEF = 10;
    localparam int F_DEF = 9;
    localparam int ACC_W = N_DEF + 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL_P,
        MUL_I,
        SUM,
        AW,
        STORE,
        DONE
    } pi_state_e;

    typedef enum logic [1:0] {
        LOOP_SPEED = 2'd0,
        LOOP_ID    = 2'd1,
        LOOP_IQ    = 2'd2
    } loop_e;

    // Integrator width for a given data width: two guard bits above N.
    function automatic int acc_width(input int n);
        return n + 2;
    endfunction

    // Saturate a wide signed value to a w-bit two's complement range.
    function automatic longint sat_w(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -hi - longint'(1);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Symmetric clamp to +/-lim; a negative limit collapses to zero.
    function automatic longint clamp_lim(input longint x, input longint lim);
        longint l;
        l = (lim < longint'(0)) ? longint'(0) : lim;
        if (x > l) begin
            return l;
        end else if (x < -l) begin
            return -l;
        end
        return x;
    endfunction

endpackage

// File: rtl/pi_scheduler_if.sv
// rtl/pi_scheduler_if.sv - control-tick, setpoint/gain and result bundle of the PI scheduler
//
// master: drives tick, refs, measurements, gains, limits; reads results/status.
// slave : the scheduler itself.
interface pi_scheduler_if #(
    parameter int N = 10
);
    logic                ctrl_tick;
    logic signed [N-1:0] speed_ref;
    logic signed [N-1:0] speed_meas;
    logic signed [N-1:0] id_ref;
    logic signed [N-1:0] id_meas;
    logic signed [N-1:0] iq_meas;
    logic signed [N-1:0] kp_speed;
    logic signed [N-1:0] ki_speed;
    logic signed [N-1:0] kaw_speed;
    logic signed [N-1:0] kp_id;
    logic signed [N-1:0] ki_id;
    logic signed [N-1:0] kaw_id;
    logic signed [N-1:0] kp_iq;
    logic signed [N-1:0] ki_iq;
    logic signed [N-1:0] kaw_iq;
    logic signed [N-1:0] speed_lim;
    logic signed [N-1:0] i_lim;
    logic signed [N-1:0] iq_ref;
    logic signed [N-1:0] vd;
    logic signed [N-1:0] vq;
    logic                busy;
    logic                done;
    logic                overrun;

    modport master (
        output ctrl_tick, speed_ref, speed_meas, id_ref, id_meas, iq_meas,
               kp_speed, ki_speed, kaw_speed, kp_id, ki_id, kaw_id,
               kp_iq, ki_iq, kaw_iq, speed_lim, i_lim,
        input  iq_ref, vd, vq, busy, done, overrun
    );

    modport slave (
        input  ctrl_tick, speed_ref, speed_meas, id_ref, id_meas, iq_meas,
               kp_speed, ki_speed, kaw_speed, kp_id, ki_id, kaw_id,
               kp_iq, ki_iq, kaw_iq, speed_lim, i_lim,
        output iq_ref, vd, vq, busy, done, overrun
    );
endinterface

// File: rtl/pi_mac.sv
// rtl/pi_mac.sv - shared registered multiplier: y = sat_ACC((a*b) >>> F), one cycle latency
//
// Ports: clk, rst (sync, active-high); a (N-bit gain), b (AW_W-bit operand);
//        y (AW_W-bit saturated, floored product, registered).
module pi_mac
    import foc_pkg::*;
#(
    parameter int N    = 10,
    parameter int F    = 9,
    parameter int AW_W = N + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [N-1:0]    a,
    input  logic signed [AW_W-1:0] b,
    output logic signed [AW_W-1:0] y
);
    localparam int PW = N + AW_W;

    logic signed [PW-1:0]   prod;
    logic signed [AW_W-1:0] y_d;
    logic signed [AW_W-1:0] y_q;

    always_comb begin
        prod = PW'(a) * PW'(b);
        // >>> on a signed product floors toward minus infinity.
        y_d  = AW_W'(sat_w(longint'(prod >>> F), AW_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/pi_scheduler.sv
// rtl/pi_scheduler.sv - time-multiplexed PI engine for the speed, d- and q-current loops
//
// Ports: clk, rst (sync, active-high); bus (pi_scheduler_if.slave) carrying
//        ctrl_tick, refs/meas, kp/ki/kaw gains, speed_lim/i_lim, and the
//        registered results iq_ref, vd, vq, busy, done, overrun.
// Build option FOC_PI_ANTIWINDUP_EN: adds the AW state (back-calculation,
//        6 cycles per loop); without it the integrator is clamped to +/-lim
//        and each loop takes 5 cycles.
module pi_scheduler
    import foc_pkg::*;
#(
    parameter int N = 10,
    parameter int F = 9
) (
    input  logic          clk,
    input  logic          rst,
    pi_scheduler_if.slave bus
);
    localparam int AW_W = acc_width(N);

    pi_state_e state_q, state_d;
    loop_e     loop_q, loop_d;
    logic      busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;

    // Snapshot of the inputs taken when a tick is accepted.
    logic signed [N-1:0] speed_ref_q, speed_ref_d, id_ref_q, id_ref_d;
    logic signed [N-1:0] meas_q[3], meas_d[3];
    logic signed [N-1:0] kp_q[3], kp_d[3];
    logic signed [N-1:0] ki_q[3], ki_d[3];
    logic signed [N-1:0] lim_q[3], lim_d[3];
`ifdef FOC_PI_ANTIWINDUP_EN
    logic signed [N-1:0] kaw_q[3], kaw_d[3];
`else
    logic unused_kaw;
    assign unused_kaw = ^{bus.kaw_speed, bus.kaw_id, bus.kaw_iq};
`endif

    logic signed [N-1:0]    out_q[3], out_d[3];
    logic signed [AW_W-1:0] acc_q[3], acc_d[3];
    logic signed [N-1:0]    err_q, err_d;
    logic signed [AW_W-1:0] p_q, p_d, raw_q, raw_d;

    logic signed [N-1:0]    cur_ref;
    logic signed [N-1:0]    sat_out;
    logic signed [AW_W-1:0] acc_new;
`ifdef FOC_PI_ANTIWINDUP_EN
    logic signed [AW_W-1:0] aw_diff;
`endif
    logic signed [N-1:0]    mac_a;
    logic signed [AW_W-1:0] mac_b, mac_y;

    pi_mac #(.N(N), .F(F), .AW_W(AW_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .a   (mac_a),
        .b   (mac_b),
        .y   (mac_y)
    );

    // Per-loop datapath values derived from the current loop's registers.
    always_comb begin
        case (loop_q)
            LOOP_SPEED: cur_ref = speed_ref_q;
            LOOP_ID:    cur_ref = id_ref_q;
            // Cascade: q-loop follows the iq_ref just written by the speed loop.
            default:    cur_ref = out_q[LOOP_SPEED];
        endcase
        sat_out = N'(clamp_lim(longint'(raw_q), longint'(lim_q[loop_q])));
        // mac_y holds the ki term in SUM and the kaw term in STORE.
        acc_new = AW_W'(sat_w(longint'(acc_q[loop_q]) + longint'(mac_y), AW_W));
`ifdef FOC_PI_ANTIWINDUP_EN
        aw_diff = AW_W'(sat_w(longint'(sat_out) - longint'(raw_q), AW_W));
`else
        acc_new = AW_W'(clamp_lim(longint'(acc_new), longint'(lim_q[loop_q])));
`endif
    end

    // Multiplier operands are presented one state ahead of where the result is used.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        case (state_q)
            MUL_P: begin
                mac_a = kp_q[loop_q];
                mac_b = AW_W'(err_q);
            end
            MUL_I: begin
                mac_a = ki_q[loop_q];
                mac_b = AW_W'(err_q);
            end
`ifdef FOC_PI_ANTIWINDUP_EN
            AW: begin
                mac_a = kaw_q[loop_q];
                mac_b = aw_diff;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        loop_d      = loop_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        speed_ref_d = speed_ref_q;
        id_ref_d    = id_ref_q;
        meas_d      = meas_q;
        kp_d        = kp_q;
        ki_d        = ki_q;
        lim_d       = lim_q;
`ifdef FOC_PI_ANTIWINDUP_EN
        kaw_d       = kaw_q;
`endif
        out_d       = out_q;
        acc_d       = acc_q;
        err_d       = err_q;
        p_d         = p_q;
        raw_d       = raw_q;

        if (bus.ctrl_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.ctrl_tick) begin
                    speed_ref_d        = bus.speed_ref;
                    id_ref_d           = bus.id_ref;
                    meas_d[LOOP_SPEED] = bus.speed_meas;
                    meas_d[LOOP_ID]    = bus.id_meas;
                    meas_d[LOOP_IQ]    = bus.iq_meas;
                    kp_d[LOOP_SPEED]   = bus.kp_speed;
                    kp_d[LOOP_ID]      = bus.kp_id;
                    kp_d[LOOP_IQ]      = bus.kp_iq;
                    ki_d[LOOP_SPEED]   = bus.ki_speed;
                    ki_d[LOOP_ID]      = bus.ki_id;
                    ki_d[LOOP_IQ]      = bus.ki_iq;
`ifdef FOC_PI_ANTIWINDUP_EN
                    kaw_d[LOOP_SPEED]  = bus.kaw_speed;
                    kaw_d[LOOP_ID]     = bus.kaw_id;
                    kaw_d[LOOP_IQ]     = bus.kaw_iq;
`endif
                    lim_d[LOOP_SPEED]  = bus.speed_lim;
                    lim_d[LOOP_ID]     = bus.i_lim;
                    lim_d[LOOP_IQ]     = bus.i_lim;
                    loop_d             = LOOP_SPEED;
                    busy_d             = 1'b1;
                    state_d            = LOAD;
                end
            end
            LOAD: begin
                err_d   = N'(sat_w(longint'(cur_ref) - longint'(meas_q[loop_q]), N));
                state_d = MUL_P;
            end
            MUL_P: begin
                state_d = MUL_I;
            end
            MUL_I: begin
                p_d     = mac_y;
                state_d = SUM;
            end
            SUM: begin
                acc_d[loop_q] = acc_new;
                raw_d         = AW_W'(sat_w(longint'(p_q) + longint'(acc_new), AW_W));
`ifdef FOC_PI_ANTIWINDUP_EN
                state_d       = AW;
`else
                state_d       = STORE;
`endif
            end
            AW: begin
                state_d = STORE;
            end
            STORE: begin
                out_d[loop_q] = sat_out;
`ifdef FOC_PI_ANTIWINDUP_EN
                acc_d[loop_q] = acc_new;
`endif
                case (loop_q)
                    LOOP_SPEED: begin
                        loop_d  = LOOP_ID;
                        state_d = LOAD;
                    end
                    LOOP_ID: begin
                        loop_d  = LOOP_IQ;
                        state_d = LOAD;
                    end
                    default: begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                endcase
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            loop_q      <= LOOP_SPEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            speed_ref_q <= '0;
            id_ref_q    <= '0;
            meas_q      <= '{default: '0};
            kp_q        <= '{default: '0};
            ki_q        <= '{default: '0};
            lim_q       <= '{default: '0};
`ifdef FOC_PI_ANTIWINDUP_EN
            kaw_q       <= '{default: '0};
`endif
            out_q       <= '{default: '0};
            acc_q       <= '{default: '0};
            err_q       <= '0;
            p_q         <= '0;
            raw_q       <= '0;
        end else begin
            state_q     <= state_d;
            loop_q      <= loop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            speed_ref_q <= speed_ref_d;
            id_ref_q    <= id_ref_d;
            meas_q      <= meas_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            lim_q       <= lim_d;
`ifdef FOC_PI_ANTIWINDUP_EN
            kaw_q       <= kaw_d;
`endif
            out_q       <= out_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            p_q         <= p_d;
            raw_q       <= raw_d;
        end
    end

    assign bus.iq_ref  = out_q[LOOP_SPEED];
    assign bus.vd      = out_q[LOOP_ID];
    assign bus.vq      = out_q[LOOP_IQ];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_pi_scheduler.sv
// tb/tb_pi_scheduler.sv - directed self-checking bench for pi_scheduler
module tb_pi_scheduler;
    localparam int N = 10;
`ifdef FOC_PI_ANTIWINDUP_EN
    localparam int L = 6;
`else
    localparam int L = 5;
`endif
    localparam int T_IQ = L + 1;
    localparam int T_VD = 2 * L + 1;
    localparam int T_VQ = 3 * L + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pi_scheduler_if #(.N(N)) bus ();

    pi_scheduler #(.N(N), .F(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cur      = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the middle of cycle c of the current sequence.
    task automatic goto(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
        end
    endtask

    // Tick is high in cycle 0; returns in the middle of cycle 1.
    task automatic tick();
        @(negedge clk);
        bus.ctrl_tick = 1'b1;
        cur = 0;
        @(negedge clk);
        bus.ctrl_tick = 1'b0;
        cur = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_defaults();
        bus.ctrl_tick  = 1'b0;
        bus.speed_ref  = '0;
        bus.speed_meas = '0;
        bus.id_ref     = '0;
        bus.id_meas    = '0;
        bus.iq_meas    = '0;
        bus.kp_speed   = '0;
        bus.ki_speed   = '0;
        bus.kaw_speed  = '0;
        bus.kp_id      = '0;
        bus.ki_id      = '0;
        bus.kaw_id     = '0;
        bus.kp_iq      = '0;
        bus.ki_iq      = '0;
        bus.kaw_iq     = '0;
        bus.speed_lim  = 10'sd511;
        bus.i_lim      = 10'sd511;
    endtask

    task automatic set_prop();
        set_defaults();
        bus.speed_ref = 10'sd200;
        bus.kp_speed  = 10'sd256;
        bus.kp_iq     = 10'sd256;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_aw[5];
        set_defaults();

        // Reset state
        do_reset();
        chk("rst_iq_ref", bus.iq_ref, 0);
        chk("rst_vd", bus.vd, 0);
        chk("rst_vq", bus.vq, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overrun", bus.overrun, 0);

        // Proportional cascade: err 200 * 0.5 = 100, then 100 * 0.5 = 50
        set_prop();
        tick();
        chk("prop_busy_c1", bus.busy, 1);
        goto(T_IQ - 1);
        chk("prop_iq_ref_before", bus.iq_ref, 0);
        goto(T_IQ);
        chk("prop_iq_ref", bus.iq_ref, 100);
        goto(T_VQ - 1);
        chk("prop_busy_last", bus.busy, 1);
        chk("prop_done_early", bus.done, 0);
        chk("prop_vq_before", bus.vq, 0);
        goto(T_VQ);
        chk("prop_vq", bus.vq, 50);
        chk("prop_done", bus.done, 1);
        chk("prop_busy_done", bus.busy, 0);
        chk("prop_vd", bus.vd, 0);
        goto(T_VQ + 1);
        chk("prop_done_pulse", bus.done, 0);
        chk("prop_vq_hold", bus.vq, 50);

        // Integral: 128 * 100 >>> 9 = 25 per tick
        do_reset();
        set_defaults();
        bus.id_ref = 10'sd100;
        bus.ki_id  = 10'sd128;
        for (int k = 1; k <= 3; k++) begin
            tick();
            goto(T_VD - 1);
            chk($sformatf("int_vd_hold_%0d", k), bus.vd, 25 * (k - 1));
            goto(T_VD);
            chk($sformatf("int_vd_%0d", k), bus.vd, 25 * k);
            goto(T_VQ + 1);
        end

        // Saturation / anti-windup: integrator must stay at 60, shown by
        // reversing the error on tick 5 (60 - 25 = 35).
        do_reset();
        set_defaults();
        bus.id_ref = 10'sd100;
        bus.ki_id  = 10'sd128;
        bus.i_lim  = 10'sd60;
        bus.kaw_id = 10'sd511;
        exp_aw = '{25, 50, 60, 60, 35};
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bus.id_ref = -10'sd100;
            tick();
            goto(T_VD);
            chk($sformatf("aw_vd_%0d", k + 1), bus.vd, exp_aw[k]);
            goto(T_VQ + 1);
        end

        // Overrun: extra tick plus input change at cycle 5 must be ignored
        do_reset();
        set_prop();
        tick();
        goto(5);
        bus.ctrl_tick = 1'b1;
        bus.speed_ref = 10'sd400;
        goto(6);
        bus.ctrl_tick = 1'b0;
        chk("ovr_flag", bus.overrun, 1);
        chk("ovr_busy", bus.busy, 1);
        goto(T_IQ);
        chk("ovr_iq_ref", bus.iq_ref, 100);
        goto(T_VQ);
        chk("ovr_vq", bus.vq, 50);
        chk("ovr_done", bus.done, 1);
        goto(T_VQ + 1);
        tick();
        goto(T_VQ);
        chk("ovr_next_iq_ref", bus.iq_ref, 200);
        chk("ovr_next_vq", bus.vq, 100);
        chk("ovr_sticky", bus.overrun, 1);
        goto(T_VQ + 1);
        do_reset();
        chk("ovr_cleared", bus.overrun, 0);

        // Reset mid-sequence at cycle 10
        set_prop();
        tick();
        goto(T_IQ);
        chk("mid_iq_ref_pre", bus.iq_ref, 100);
        goto(10);
        rst = 1'b1;
        goto(11);
        rst = 1'b0;
        chk("mid_iq_ref", bus.iq_ref, 0);
        chk("mid_vd", bus.vd, 0);
        chk("mid_vq", bus.vq, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_done", bus.done, 0);
        tick();
        chk("mid_restart_busy", bus.busy, 1);
        goto(T_IQ);
        chk("mid_restart_iq_ref", bus.iq_ref, 100);
        goto(T_VQ);
        chk("mid_restart_vq", bus.vq, 50);
        chk("mid_restart_done", bus.done, 1);
        goto(T_VQ + 1);

        // Negative current limit acts as zero
        do_reset();
        set_prop();
        bus.i_lim = -10'sd5;
        tick();
        goto(T_VQ);
        chk("neglim_iq_ref", bus.iq_ref, 100);
        chk("neglim_vq", bus.vq, 0);
        goto(T_VQ + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
